// File: rtl/usb_tx_scheduler.sv
// USB transmit scheduler: arbitrates handshake vs data requests onto tx_packet,
// tracks the DATA0/DATA1 toggle and supervises each transfer through an inter-packet gap.
module usb_tx_scheduler #(
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned GAP_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       hs_req,
    input  logic [1:0] hs_pid,
    input  logic       data_req,
    input  logic       data_ack,
    input  logic       toggle_reset,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    output logic [2:0] tx_packet,
    output logic       hs_done,
    output logic       data_done,
    output logic       xfer_err,
    output logic       data_toggle,
    output logic       sched_busy
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        BUSY,
        GAP
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(START_TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST     = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic       owner_hs;
    logic [1:0] pid_q;
    logic [7:0] timeout_cnt;
    logic [7:0] gap_cnt;
    logic       err_seen;
    logic       hs_reserved;
    logic       timeout_hit;
    logic       done_pulse;
    logic       unused_occupancy;

    // Occupancy is status only; a zero count still issues a zero-length packet.
    assign unused_occupancy = ^buffer_occupancy;

    assign hs_reserved = hs_req && (hs_pid == 2'd3);
    assign timeout_hit = !tx_transfer_active && (timeout_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (hs_req) begin
                    if (!hs_reserved) begin
                        next_state = ISSUE;
                    end
                end else if (data_req) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = WAIT_START;
            WAIT_START: begin
                if (tx_transfer_active) begin
                    next_state = BUSY;
                end else if (timeout_hit) begin
                    next_state = GAP;
                end
            end
            BUSY: begin
                if (!tx_transfer_active) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Owner and pid are captured at grant so a dropped request cannot alter the command.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            owner_hs    <= 1'b0;
            pid_q       <= 2'd0;
            timeout_cnt <= 8'd0;
            gap_cnt     <= 8'd0;
            err_seen    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs_req) begin
                        owner_hs <= 1'b1;
                        pid_q    <= hs_pid;
                    end else if (data_req) begin
                        owner_hs <= 1'b0;
                    end
                end
                ISSUE: begin
                    timeout_cnt <= 8'd0;
                    err_seen    <= 1'b0;
                end
                WAIT_START: begin
                    gap_cnt <= 8'd0;
                    if (!tx_transfer_active) begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                BUSY: begin
                    gap_cnt <= 8'd0;
                    if (tx_error) begin
                        err_seen <= 1'b1;
                    end
                end
                GAP: gap_cnt <= gap_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            data_toggle <= 1'b0;
        end else if (toggle_reset) begin
            data_toggle <= 1'b0;
        end else if (data_ack) begin
            data_toggle <= ~data_toggle;
        end
    end

    // Outputs are held quiet while reset is asserted so an aborted transfer never reports done.
    always_comb begin
        tx_packet  = 3'd0;
        done_pulse = 1'b0;
        xfer_err   = 1'b0;
        sched_busy = 1'b0;
        if (n_rst) begin
            sched_busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (hs_reserved) begin
                        done_pulse = 1'b1;
                        xfer_err   = 1'b1;
                    end
                end
                ISSUE: begin
                    tx_packet = owner_hs ? (3'd3 + {1'b0, pid_q}) : (3'd1 + {2'b00, data_toggle});
                end
                WAIT_START: begin
                    if (timeout_hit) begin
                        done_pulse = 1'b1;
                        xfer_err   = 1'b1;
                    end
                end
                BUSY: begin
                    if (!tx_transfer_active) begin
                        done_pulse = 1'b1;
                        xfer_err   = err_seen | tx_error;
                    end
                end
                default: ;
            endcase
        end
        hs_done   = done_pulse & (owner_hs | (state == IDLE));
        data_done = done_pulse & !owner_hs & (state != IDLE);
    end

endmodule
